mc_control: RTL and testbench

Multi-cycle control sequencer that drives the 32-bit ALU from the other side of its control interface. Accepts one instruction word per handshake and decodes opcode/funct into `aluCtrl`, `aluSrc`, the sign-extended immediate and register-file addresses. It then samples the ALU's `zero`/`overflow` flags and issues a write-back, a branch decision or an exception. Sits between the instruction source and the ALU/register file in the multi-cycle datapath.

---
 rtl/mc_control_pkg.sv | 54 +++++
 rtl/mc_control_if.sv | 32 +++
 rtl/mc_control_alu_ctrl_decode.sv | 57 +++++
 rtl/mc_control.sv | 141 ++++++++++++++
 tb/tb_mc_control.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcodes, functs,
// ALU control encodings, FSM states and exception codes.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDU = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_BEQ  = 4'd9,
        ALU_BNE  = 4'd10
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_TRAP   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'd0,
        EXC_OVF     = 2'd1,
        EXC_ILLEGAL = 2'd2
    } exc_e;

    // Only the signed add/sub forms trap on overflow (ADDI shares ALU_ADD).
    function automatic logic ovf_checked(input alu_ctrl_e c);
        return (c == ALU_ADD) || (c == ALU_SUB);
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Instruction handshake, ALU control/flags and write-back/branch/retire bus
// between the instruction source/datapath (master) and mc_control (slave).
interface mc_control_if;
    logic [31:0] instr;
    logic        instrValid;
    logic        instrReady;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic        aluSrc;
    logic [3:0]  aluCtrl;
    logic [31:0] imm;
    logic        aluZero;
    logic        aluOverflow;
    logic        regWrite;
    logic [4:0]  wrAddr;
    logic        branchTaken;
    logic [31:0] branchOffset;
    logic        done;
    logic [1:0]  excCode;

    modport master (
        output instr, instrValid, aluZero, aluOverflow,
        input  instrReady, rsAddr, rtAddr, aluSrc, aluCtrl, imm, regWrite,
               wrAddr, branchTaken, branchOffset, done, excCode
    );

    modport slave (
        input  instr, instrValid, aluZero, aluOverflow,
        output instrReady, rsAddr, rtAddr, aluSrc, aluCtrl, imm, regWrite,
               wrAddr, branchTaken, branchOffset, done, excCode
    );
endinterface

// File: rtl/mc_control_alu_ctrl_decode.sv
// Combinational opcode/funct decoder: ALU op, operand select, branch and
// destination-register selection, plus a legality flag.
module alu_ctrl_decode
    import mc_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output alu_ctrl_e  o_aluCtrl,
    output logic       o_aluSrc,
    output logic       o_isBranch,
    output logic       o_regDstRd,
    output logic       o_legal
);

    always_comb begin
        o_aluCtrl  = ALU_ADD;
        o_aluSrc   = 1'b0;
        o_isBranch = 1'b0;
        o_regDstRd = 1'b0;
        o_legal    = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                o_regDstRd = 1'b1;
                case (i_funct)
                    FN_ADD:  o_aluCtrl = ALU_ADD;
                    FN_ADDU: o_aluCtrl = ALU_ADDU;
                    FN_SUB:  o_aluCtrl = ALU_SUB;
                    FN_SUBU: o_aluCtrl = ALU_SUBU;
                    FN_AND:  o_aluCtrl = ALU_AND;
                    FN_OR:   o_aluCtrl = ALU_OR;
                    FN_SLL:  o_aluCtrl = ALU_SLL;
                    FN_SRL:  o_aluCtrl = ALU_SRL;
                    FN_SLT:  o_aluCtrl = ALU_SLT;
                    default: o_legal   = 1'b0;
                endcase
            end
            OP_ADDI: begin
                o_aluCtrl = ALU_ADD;
                o_aluSrc  = 1'b1;
            end
            OP_ADDIU: begin
                o_aluCtrl = ALU_ADDU;
                o_aluSrc  = 1'b1;
            end
            OP_BEQ: begin
                o_aluCtrl  = ALU_BEQ;
                o_isBranch = 1'b1;
            end
            OP_BNE: begin
                o_aluCtrl  = ALU_BNE;
                o_isBranch = 1'b1;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control sequencer: IDLE -> DECODE -> EXEC -> WB (or TRAP).
// Optional MC_CONTROL_PERF_EN adds retireCount/trapCount counters.
module mc_control
    import mc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mc_control_if.slave  bus
`ifdef MC_CONTROL_PERF_EN
    ,
    output logic [31:0]  retireCount,
    output logic [31:0]  trapCount
`endif
);

    state_e      r_state, w_next;
    logic        w_accept;
    logic        w_ready;

    alu_ctrl_e   w_decCtrl;
    logic        w_decSrc, w_decBranch, w_decRd, w_decLegal;

    alu_ctrl_e   r_aluCtrl;
    logic        r_aluSrc, r_isBranch, r_legal;
    logic [31:0] r_imm;
    logic [4:0]  r_rs, r_rt, r_wr;
    logic        r_done, r_regWrite, r_branchTaken;
    exc_e        r_exc;

    logic        w_ovfTrap;
    logic        w_toWb;
    logic        w_unused;

    assign w_unused = ^bus.instr[10:6];

    alu_ctrl_decode u_dec (
        .i_opcode   (bus.instr[31:26]),
        .i_funct    (bus.instr[5:0]),
        .o_aluCtrl  (w_decCtrl),
        .o_aluSrc   (w_decSrc),
        .o_isBranch (w_decBranch),
        .o_regDstRd (w_decRd),
        .o_legal    (w_decLegal)
    );

    assign w_ready = (r_state == S_IDLE) && !rst;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.instrValid && w_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: w_next = r_legal ? S_EXEC : S_TRAP;
            S_EXEC:   w_next = S_WB;
            S_WB:     w_next = S_IDLE;
            S_TRAP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Retire outcome is resolved on the EXEC->WB edge from the live ALU flags,
    // so the WB-cycle strobes come straight out of flops.
    assign w_toWb    = (w_next == S_WB);
    assign w_ovfTrap = !r_isBranch && bus.aluOverflow && ovf_checked(r_aluCtrl);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_aluCtrl     <= ALU_ADD;
            r_aluSrc      <= 1'b0;
            r_isBranch    <= 1'b0;
            r_legal       <= 1'b0;
            r_imm         <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_wr          <= '0;
            r_done        <= 1'b0;
            r_regWrite    <= 1'b0;
            r_branchTaken <= 1'b0;
            r_exc         <= EXC_NONE;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_aluCtrl  <= w_decCtrl;
                r_aluSrc   <= w_decSrc;
                r_isBranch <= w_decBranch;
                r_legal    <= w_decLegal;
                r_imm      <= {{16{bus.instr[15]}}, bus.instr[15:0]};
                r_rs       <= bus.instr[25:21];
                r_rt       <= bus.instr[20:16];
                r_wr       <= w_decRd ? bus.instr[15:11] : bus.instr[20:16];
            end
            r_done        <= w_toWb || (w_next == S_TRAP);
            r_regWrite    <= w_toWb && !r_isBranch && !w_ovfTrap && (r_wr != 5'd0);
            r_branchTaken <= w_toWb && r_isBranch && !bus.aluZero;
            if (w_next == S_TRAP)
                r_exc <= EXC_ILLEGAL;
            else if (w_toWb && w_ovfTrap)
                r_exc <= EXC_OVF;
            else
                r_exc <= EXC_NONE;
        end
    end

`ifdef MC_CONTROL_PERF_EN
    logic [31:0] r_retireCount, r_trapCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retireCount <= '0;
            r_trapCount   <= '0;
        end else if (r_done) begin
            r_retireCount <= r_retireCount + 32'd1;
            if (r_exc != EXC_NONE)
                r_trapCount <= r_trapCount + 32'd1;
        end
    end

    assign retireCount = r_retireCount;
    assign trapCount   = r_trapCount;
`endif

    assign bus.instrReady   = w_ready;
    assign bus.rsAddr       = r_rs;
    assign bus.rtAddr       = r_rt;
    assign bus.aluSrc       = r_aluSrc;
    assign bus.aluCtrl      = r_aluCtrl;
    assign bus.imm          = r_imm;
    assign bus.regWrite     = r_regWrite;
    assign bus.wrAddr       = r_wr;
    assign bus.branchTaken  = r_branchTaken;
    assign bus.branchOffset = {r_imm[29:0], 2'b00};
    assign bus.done         = r_done;
    assign bus.excCode      = r_exc;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: scoreboard of expected retire results,
// one task per scenario.
module tb_mc_control;

    typedef struct packed {
        logic [1:0]  exc;
        logic        rw;
        logic        bt;
        logic [3:0]  ctrl;
        logic        src;
        logic [31:0] imm;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    res_t sb[$];

    mc_control_if bus ();

`ifdef MC_CONTROL_PERF_EN
    logic [31:0] retireCount, trapCount;
    mc_control dut (.clk(clk), .rst(rst), .bus(bus),
                    .retireCount(retireCount), .trapCount(trapCount));
`else
    mc_control dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
        $fatal(1, "timeout");
    end

    // Called at a negedge; returns negedges from handshake to done (-1 on timeout).
    task automatic send(input logic [31:0] ins, input logic z, input logic o, output int lat);
        int k = 0;
        while (!bus.instrReady && k < 8) begin
            @(negedge clk);
            k++;
        end
        bus.instr = ins; bus.aluZero = z; bus.aluOverflow = o; bus.instrValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instrValid = 1'b0;
        lat = 1;
        while (!bus.done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic test_reset();
        logic [127:0] obs;
        bus.instrValid = 1'b0; bus.instr = '0; bus.aluZero = 1'b0; bus.aluOverflow = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {bus.instrReady, bus.done, bus.regWrite, bus.branchTaken, bus.excCode,
               bus.aluCtrl, bus.aluSrc, bus.imm, bus.wrAddr, bus.rsAddr, bus.rtAddr,
               bus.branchOffset};
        n_cmp++;
        if (obs !== 128'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required 0", obs);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.instrReady !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b, required 1", bus.instrReady);
        end
    endtask

    task automatic test_alu();
        logic [31:0] ins [9] = '{32'h00221820, 32'h2085FFFC, 32'h2485FFFC, 32'h00221822,
                                 32'h00221823, 32'h00221824, 32'h0022182A, 32'h00220020,
                                 32'h00000000};
        logic        z   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        o   [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [4:0]  wr  [9] = '{5'd3, 5'd5, 5'd5, 5'd3, 5'd3, 5'd3, 5'd3, 5'd0, 5'd0};
        logic [4:0]  rs  [9] = '{5'd1, 5'd4, 5'd4, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd0};
        res_t        tab [9] = '{
            '{2'd0, 1'b1, 1'b0, 4'd0, 1'b0, 32'h00001820},
            '{2'd1, 1'b0, 1'b0, 4'd0, 1'b1, 32'hFFFFFFFC},
            '{2'd0, 1'b1, 1'b0, 4'd1, 1'b1, 32'hFFFFFFFC},
            '{2'd1, 1'b0, 1'b0, 4'd2, 1'b0, 32'h00001822},
            '{2'd0, 1'b1, 1'b0, 4'd3, 1'b0, 32'h00001823},
            '{2'd0, 1'b1, 1'b0, 4'd4, 1'b0, 32'h00001824},
            '{2'd0, 1'b1, 1'b0, 4'd8, 1'b0, 32'h0000182A},
            '{2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h00000020},
            '{2'd1, 1'b0, 1'b0, 4'd6, 1'b0, 32'h00000000}};
        res_t e, obs;
        int   lat;
        // SLL with overflow high must not trap.
        tab[8].exc = 2'd0;
        for (int i = 0; i < 9; i++) begin
            sb.push_back(tab[i]);
            send(ins[i], z[i], o[i], lat);
            e   = sb.pop_front();
            obs = {bus.excCode, bus.regWrite, bus.branchTaken, bus.aluCtrl, bus.aluSrc, bus.imm};
            n_cmp++;
            if (lat !== 3) begin
                n_err++;
                $display("FAIL alu_latency[%0d]: got %0d, required 3", i, lat);
            end
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL alu_result[%0d] {exc,rw,bt,ctrl,src,imm}: got %h, required %h", i, obs, e);
            end
            n_cmp++;
            if ({bus.wrAddr, bus.rsAddr} !== {wr[i], rs[i]}) begin
                n_err++;
                $display("FAIL alu_addr[%0d] {wr,rs}: got %h, required %h", i, {bus.wrAddr, bus.rsAddr}, {wr[i], rs[i]});
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.done, bus.regWrite, bus.excCode} !== 4'd0) begin
            n_err++;
            $display("FAIL alu_pulse_width {done,rw,exc}: got %b, required 0", {bus.done, bus.regWrite, bus.excCode});
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins  [5] = '{32'h10220003, 32'h10220003, 32'h14220003, 32'h14220003, 32'h1022FFFF};
        logic        z    [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] boff [5] = '{32'd12, 32'd12, 32'd12, 32'd12, 32'hFFFFFFFC};
        res_t        tab  [5] = '{
            '{2'd0, 1'b0, 1'b1, 4'd9,  1'b0, 32'h00000003},
            '{2'd0, 1'b0, 1'b0, 4'd9,  1'b0, 32'h00000003},
            '{2'd0, 1'b0, 1'b1, 4'd10, 1'b0, 32'h00000003},
            '{2'd0, 1'b0, 1'b0, 4'd10, 1'b0, 32'h00000003},
            '{2'd0, 1'b0, 1'b1, 4'd9,  1'b0, 32'hFFFFFFFF}};
        res_t e, obs;
        int   lat;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(tab[i]);
            send(ins[i], z[i], 1'b0, lat);
            e   = sb.pop_front();
            obs = {bus.excCode, bus.regWrite, bus.branchTaken, bus.aluCtrl, bus.aluSrc, bus.imm};
            n_cmp++;
            if (lat !== 3 || obs !== e) begin
                n_err++;
                $display("FAIL branch[%0d] lat/{exc,rw,bt,ctrl,src,imm}: got %0d/%h, required 3/%h", i, lat, obs, e);
            end
            n_cmp++;
            if (bus.branchOffset !== boff[i]) begin
                n_err++;
                $display("FAIL branch_offset[%0d]: got %h, required %h", i, bus.branchOffset, boff[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [3] = '{32'hFC000000, 32'h0000003F, 32'h8C220000};
        logic [3:0]  e, obs;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{2'd2, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0});
            send(ins[i], 1'b0, 1'b1, lat);
            e   = {sb[0].exc, sb[0].rw, sb[0].bt};
            void'(sb.pop_front());
            obs = {bus.excCode, bus.regWrite, bus.branchTaken};
            n_cmp++;
            if (lat !== 2 || obs !== e) begin
                n_err++;
                $display("FAIL illegal[%0d] lat/{exc,rw,bt}: got %0d/%b, required 2/%b", i, lat, obs, e);
            end
            @(negedge clk);
            n_cmp++;
            if ({bus.done, bus.excCode, bus.instrReady} !== 4'b0001) begin
                n_err++;
                $display("FAIL illegal_after[%0d] {done,exc,ready}: got %b, required 0001", i, {bus.done, bus.excCode, bus.instrReady});
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_rdy = 0, n_done = 0, n_bad = 0;
        bus.instr = 32'h00221820; bus.aluZero = 1'b0; bus.aluOverflow = 1'b0;
        @(negedge clk);
        bus.instrValid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (bus.instrReady) n_rdy++;
            if (bus.done) n_done++;
            if (bus.instrReady !== ((i % 4) == 0)) n_bad++;
            @(negedge clk);
        end
        bus.instrValid = 1'b0;
        n_cmp++;
        if (n_rdy != 4 || n_bad != 0) begin
            n_err++;
            $display("FAIL b2b_ready: got %0d ready cycles (%0d misplaced), required 4 (0)", n_rdy, n_bad);
        end
        n_cmp++;
        if (n_done != 4) begin
            n_err++;
            $display("FAIL b2b_done: got %0d, required 4", n_done);
        end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        @(negedge clk);
        bus.instr = 32'h00221820; bus.instrValid = 1'b1;
        @(posedge clk);
        @(negedge clk);          // DECODE
        bus.instrValid = 1'b0;
        @(negedge clk);          // EXEC
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.done, bus.regWrite, bus.instrReady} !== 3'b000) begin
            n_err++;
            $display("FAIL midrst_during {done,rw,ready}: got %b, required 000", {bus.done, bus.regWrite, bus.instrReady});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.instrReady !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_ready: got %b, required 1", bus.instrReady);
        end
        for (int i = 0; i < 5; i++) begin
            if (bus.done || bus.regWrite) n_done++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_done != 0) begin
            n_err++;
            $display("FAIL midrst_no_retire: got %0d strobes, required 0", n_done);
        end
    endtask

`ifdef MC_CONTROL_PERF_EN
    task automatic test_perf();
        int lat;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(32'h00221820, 1'b0, 1'b0, lat);
        send(32'h2085FFFC, 1'b0, 1'b0, lat);
        send(32'h10220003, 1'b0, 1'b0, lat);
        send(32'hFC000000, 1'b0, 1'b0, lat);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (retireCount !== 32'd4 || trapCount !== 32'd1) begin
            n_err++;
            $display("FAIL perf_counts: got %0d/%0d, required 4/1", retireCount, trapCount);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (retireCount !== 32'd0 || trapCount !== 32'd0) begin
            n_err++;
            $display("FAIL perf_reset: got %0d/%0d, required 0/0", retireCount, trapCount);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef MC_CONTROL_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
